// File: rtl/edit_ctrl_pkg.sv
// Shared definitions for the text-edit controller: FSM state encoding,
// ASCII control codes and a width helper.
package edit_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_CHAR  = 2'd1,
        ST_WR_SPACE = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Index width for a range of n values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edit_ctrl_if.sv
// Character-buffer write port: request/acknowledge handshake with address and data.
interface edit_ctrl_if #(
    parameter int AW = 5
) ();

    logic          wr_req;
    logic          wr_ack;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_dat;

    modport master (output wr_req, output wr_addr, output wr_dat, input  wr_ack);
    modport slave  (input  wr_req, input  wr_addr, input  wr_dat, output wr_ack);

endinterface

// File: rtl/edit_ctrl_cursor_pos.sv
// Cursor row/column register with left/right/down moves.
// Build option CURSOR_WRAP_EN: moving right off the last column wraps to the next row.
module edit_ctrl_cursor_pos
    import edit_ctrl_pkg::*;
#(
    parameter  int COLS = 16,
    parameter  int ROWS = 2,
    localparam int RW   = clog2_min1(ROWS),
    localparam int CW   = clog2_min1(COLS)
) (
    input  logic          clk,
    input  logic          i_arst_n,
    input  logic          i_clr,
    input  logic          i_left,
    input  logic          i_right,
    input  logic          i_down,
    output logic [RW-1:0] o_row,
    output logic [CW-1:0] o_col
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [RW-1:0] w_row_inc;

    assign w_row_inc = (r_row == ROW_MAX) ? '0 : r_row + 1'b1;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_left) begin
            if (r_col != '0) begin
                r_col <= r_col - 1'b1;
            end else if (r_row != '0) begin
                r_row <= r_row - 1'b1;
                r_col <= COL_MAX;
            end
        end else if (i_right) begin
            if (r_col != COL_MAX) begin
                r_col <= r_col + 1'b1;
            end else begin
`ifdef CURSOR_WRAP_EN
                r_row <= w_row_inc;
                r_col <= '0;
`else
                r_col <= r_col;
`endif
            end
        end else if (i_down) begin
            r_row <= w_row_inc;
        end
    end

    assign o_row = r_row;
    assign o_col = r_col;

endmodule

// File: rtl/edit_ctrl.sv
// Text-edit controller: turns character and cursor strobes into buffer writes.
// Build option CURSOR_WRAP_EN selects right-edge wrap (default: saturate).
module edit_ctrl
    import edit_ctrl_pkg::*;
#(
    parameter  int COLS = 16,
    parameter  int ROWS = 2,
    parameter  int AW   = 5,
    localparam int RW   = clog2_min1(ROWS),
    localparam int CW   = clog2_min1(COLS)
) (
    input  logic            clk,
    input  logic            i_arst_n,
    input  logic            i_sclr,
    input  logic [7:0]      i_ascii,
    input  logic            i_ascii_en,
    input  logic            i_right_en,
    input  logic            i_down_en,
    input  logic            i_left_en,
    edit_ctrl_if.master     wr_if,
    output logic [RW-1:0]   o_cur_row,
    output logic [CW-1:0]   o_cur_col,
    output logic            o_busy,
    output logic            o_drop
);

    state_e        r_state;
    logic          r_wr_req;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_dat;
    logic          r_drop;

    state_e        w_state_nxt;
    logic          w_req_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic [7:0]    w_dat_nxt;
    logic          w_drop_nxt;
    logic          w_mv_left;
    logic          w_mv_right;
    logic          w_mv_down;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic [AW-1:0] w_cur_addr;
    logic [2:0]    w_n_strobes;
    logic          w_at_origin;

    edit_ctrl_cursor_pos #(.COLS(COLS), .ROWS(ROWS)) u_cursor_pos (
        .clk      (clk),
        .i_arst_n (i_arst_n),
        .i_clr    (i_sclr),
        .i_left   (w_mv_left),
        .i_right  (w_mv_right),
        .i_down   (w_mv_down),
        .o_row    (w_row),
        .o_col    (w_col)
    );

    assign w_cur_addr  = AW'(w_row) * AW'(COLS) + AW'(w_col);
    assign w_at_origin = (w_row == '0) && (w_col == '0);
    assign w_n_strobes = 3'(i_ascii_en) + 3'(i_left_en) + 3'(i_right_en) + 3'(i_down_en);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_wr_req;
        w_addr_nxt  = r_wr_addr;
        w_dat_nxt   = r_wr_dat;
        w_drop_nxt  = 1'b0;
        w_mv_left   = 1'b0;
        w_mv_right  = 1'b0;
        w_mv_down   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only one strobe is accepted; any others this cycle share one drop pulse.
                w_drop_nxt = (w_n_strobes > 3'd1);
                if (i_ascii_en) begin
                    if (i_ascii != ASCII_BS) begin
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = w_cur_addr;
                        w_dat_nxt   = i_ascii;
                        w_state_nxt = ST_WR_CHAR;
                    end else if (!w_at_origin) begin
                        w_mv_left   = 1'b1;
                        w_state_nxt = ST_WR_SPACE;
                    end
                end else if (i_left_en) begin
                    w_mv_left = 1'b1;
                end else if (i_right_en) begin
                    w_mv_right = 1'b1;
                end else if (i_down_en) begin
                    w_mv_down = 1'b1;
                end
            end
            ST_WR_CHAR: begin
                w_drop_nxt = (w_n_strobes != 3'd0);
                if (wr_if.wr_ack) begin
                    w_req_nxt   = 1'b0;
                    w_mv_right  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_SPACE: begin
                w_drop_nxt = (w_n_strobes != 3'd0);
                // First cycle here the cursor has just stepped left; issue the blank at it.
                if (!r_wr_req) begin
                    w_req_nxt  = 1'b1;
                    w_addr_nxt = w_cur_addr;
                    w_dat_nxt  = ASCII_SPACE;
                end else if (wr_if.wr_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state   <= ST_IDLE;
            r_wr_req  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_dat  <= 8'h00;
            r_drop    <= 1'b0;
        end else if (i_sclr) begin
            r_state   <= ST_IDLE;
            r_wr_req  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_dat  <= 8'h00;
            r_drop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_req  <= w_req_nxt;
            r_wr_addr <= w_addr_nxt;
            r_wr_dat  <= w_dat_nxt;
            r_drop    <= w_drop_nxt;
        end
    end

    assign wr_if.wr_req  = r_wr_req;
    assign wr_if.wr_addr = r_wr_addr;
    assign wr_if.wr_dat  = r_wr_dat;
    assign o_cur_row     = w_row;
    assign o_cur_col     = w_col;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_drop        = r_drop;

endmodule

// File: tb/tb_edit_ctrl.sv
// Bench for edit_ctrl: directed scenarios plus random strobes against a
// linear-position reference model; honours CURSOR_WRAP_EN like the RTL.
module tb_edit_ctrl;

    localparam int COLS = 16;
    localparam int ROWS = 2;
    localparam int AW   = 5;
    localparam int NPOS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       i_arst_n;
    logic       i_sclr;
    logic [7:0] i_ascii;
    logic       i_ascii_en;
    logic       i_right_en;
    logic       i_down_en;
    logic       i_left_en;
    logic [0:0] o_cur_row;
    logic [3:0] o_cur_col;
    logic       o_busy;
    logic       o_drop;

    always #5 clk = ~clk;

    edit_ctrl_if #(.AW(AW)) wr_if ();

    edit_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk        (clk),
        .i_arst_n   (i_arst_n),
        .i_sclr     (i_sclr),
        .i_ascii    (i_ascii),
        .i_ascii_en (i_ascii_en),
        .i_right_en (i_right_en),
        .i_down_en  (i_down_en),
        .i_left_en  (i_left_en),
        .wr_if      (wr_if),
        .o_cur_row  (o_cur_row),
        .o_cur_col  (o_cur_col),
        .o_busy     (o_busy),
        .o_drop     (o_drop)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: cursor is a linear position p = row*COLS + col.
    int m_pos;
    bit m_req;
    int m_addr;
    int m_dat;
    bit m_busy;
    bit m_char;
    bit m_space_wait;
    bit m_drop;

    function automatic int pos_left(input int p);
        return (p > 0) ? p - 1 : 0;
    endfunction

    function automatic int pos_right(input int p);
`ifdef CURSOR_WRAP_EN
        return (p + 1) % NPOS;
`else
        return (p % COLS == COLS - 1) ? p : p + 1;
`endif
    endfunction

    function automatic int pos_down(input int p);
        return (p + COLS) % NPOS;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_req = 0; m_addr = 0; m_dat = 0;
        m_busy = 0; m_char = 0; m_space_wait = 0; m_drop = 0;
    endtask

    task automatic model_step();
        int n;
        n = int'(i_ascii_en) + int'(i_left_en) + int'(i_right_en) + int'(i_down_en);
        if (i_sclr) begin
            model_reset();
        end else if (!m_busy) begin
            m_drop = (n > 1);
            if (i_ascii_en) begin
                if (i_ascii != 8'h08) begin
                    m_req = 1; m_addr = m_pos; m_dat = int'(i_ascii);
                    m_busy = 1; m_char = 1;
                end else if (m_pos != 0) begin
                    m_pos = m_pos - 1; m_busy = 1; m_space_wait = 1;
                end
            end else if (i_left_en)  m_pos = pos_left(m_pos);
            else if (i_right_en) m_pos = pos_right(m_pos);
            else if (i_down_en)  m_pos = pos_down(m_pos);
        end else begin
            m_drop = (n > 0);
            if (m_space_wait) begin
                m_space_wait = 0; m_req = 1; m_addr = m_pos; m_dat = 32'h20;
            end else if (wr_if.wr_ack) begin
                m_req = 0; m_busy = 0;
                if (m_char) m_pos = pos_right(m_pos);
                m_char = 0;
            end
        end
    endtask

    task automatic check_all();
        check("wr_req",  32'(wr_if.wr_req),  32'(m_req));
        check("wr_addr", 32'(wr_if.wr_addr), 32'(m_addr));
        check("wr_dat",  32'(wr_if.wr_dat),  32'(m_dat));
        check("cur_row", 32'(o_cur_row),     32'(m_pos / COLS));
        check("cur_col", 32'(o_cur_col),     32'(m_pos % COLS));
        check("busy",    32'(o_busy),        32'(m_busy));
        check("drop",    32'(o_drop),        32'(m_drop));
    endtask

    task automatic clear_inputs();
        i_sclr = 0; i_ascii_en = 0; i_ascii = 8'h00;
        i_left_en = 0; i_right_en = 0; i_down_en = 0;
        wr_if.wr_ack = 0;
    endtask

    // One clock: inputs already driven; model follows the edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        clear_inputs();
    endtask

    task automatic send_char(input logic [7:0] ch);
        i_ascii_en = 1; i_ascii = ch; tick();
    endtask

    task automatic move_right(input int times);
        for (int i = 0; i < times; i++) begin
            i_right_en = 1; tick();
        end
    endtask

    initial begin
        clear_inputs();
        i_arst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        i_arst_n = 1;
        tick();

        // Char 'A' with ack in the fourth cycle of the request.
        send_char(8'h41);
        check("r34_req_c1", 32'(wr_if.wr_req), 32'd1);
        tick(); tick();
        check("r34_addr", 32'(wr_if.wr_addr), 32'd0);
        check("r34_dat",  32'(wr_if.wr_dat),  32'h41);
        wr_if.wr_ack = 1; tick();
        check("r34_req_off", 32'(wr_if.wr_req), 32'd0);
        check("r34_col", 32'(o_cur_col), 32'd1);

        // Backspace from (0,3).
        move_right(2);
        i_ascii_en = 1; i_ascii = 8'h08; tick();
        check("r35_col", 32'(o_cur_col), 32'd2);
        check("r35_req_lat", 32'(wr_if.wr_req), 32'd0);
        tick();
        check("r35_addr", 32'(wr_if.wr_addr), 32'd2);
        check("r35_dat",  32'(wr_if.wr_dat),  32'h20);
        wr_if.wr_ack = 1; tick();
        check("r35_busy", 32'(o_busy), 32'd0);
        check("r35_col2", 32'(o_cur_col), 32'd2);

        // Right edge.
        move_right(13);
        check("r36_col15", 32'(o_cur_col), 32'd15);
        move_right(1);
`ifdef CURSOR_WRAP_EN
        check("r36_row", 32'(o_cur_row), 32'd1);
        check("r36_col", 32'(o_cur_col), 32'd0);
`else
        check("r36_row", 32'(o_cur_row), 32'd0);
        check("r36_col", 32'(o_cur_col), 32'd15);
`endif

        // Simultaneous ascii + left + down.
        i_sclr = 1; tick();
        move_right(4);
        i_ascii_en = 1; i_ascii = 8'h42; i_left_en = 1; i_down_en = 1; tick();
        check("r37_drop", 32'(o_drop), 32'd1);
        check("r37_col",  32'(o_cur_col), 32'd4);
        tick();
        check("r37_drop_once", 32'(o_drop), 32'd0);
        wr_if.wr_ack = 1; tick();
        check("r37_col_ack", 32'(o_cur_col), 32'd5);

        // Right strobe while busy with a char write.
        send_char(8'h43);
        i_right_en = 1; tick();
        check("r38_drop", 32'(o_drop), 32'd1);
        check("r38_col",  32'(o_cur_col), 32'd5);
        wr_if.wr_ack = 1; tick();
        check("r38_col_ack", 32'(o_cur_col), 32'd6);

        // Backspace at origin does nothing.
        i_sclr = 1; tick();
        i_ascii_en = 1; i_ascii = 8'h08; tick();
        check("bs_origin_busy", 32'(o_busy), 32'd0);
        check("bs_origin_drop", 32'(o_drop), 32'd0);

        // Async reset mid-write, then a late ack.
        send_char(8'h44);
        i_arst_n = 0;
        #1;
        model_reset();
        check_all();
        #2;
        i_arst_n = 1;
        wr_if.wr_ack = 1; tick();
        check("r39_col", 32'(o_cur_col), 32'd0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            i_ascii_en   = ($urandom_range(0, 99) < 15);
            i_ascii      = ($urandom_range(0, 4) == 0) ? 8'h08 : 8'($urandom_range(32, 126));
            i_left_en    = ($urandom_range(0, 99) < 10);
            i_right_en   = ($urandom_range(0, 99) < 12);
            i_down_en    = ($urandom_range(0, 99) < 8);
            wr_if.wr_ack = ($urandom_range(0, 99) < 35);
            i_sclr       = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/edit_ctrl.md
EDIT_CTRL -- requirements
Module: edit_ctrl

Interface
REQ-001 Parameter COLS, default 16, characters per row (>=2).
REQ-002 Parameter ROWS, default 2, rows of text buffer (>=1).
REQ-003 Parameter AW, default 5, buffer address width; SHALL satisfy 2**AW >= ROWS*COLS.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 i_arst_n  in  1  asynchronous active-low reset.
REQ-006 i_sclr  in  1  synchronous clear, same effect as reset.
REQ-007 i_ascii  in  8  character code; 8'h08 = backspace.
REQ-008 i_ascii_en  in  1  one-cycle strobe qualifying i_ascii.
REQ-009 i_right_en / i_down_en / i_left_en  in  1 each  one-cycle cursor-move strobes.
REQ-010 o_wr_req  out  1  buffer write request, held until acknowledged.
REQ-011 i_wr_ack  in  1  buffer write acknowledge.
REQ-012 o_wr_addr  out  AW  write address = row*COLS + col.
REQ-013 o_wr_dat  out  8  write data.
REQ-014 o_cur_row  out  clog2(ROWS) (min 1)  cursor row; o_cur_col  out  clog2(COLS)  cursor column.
REQ-015 o_busy  out  1  high while not IDLE; o_drop  out  1  one-cycle pulse when an event is discarded.

Function
REQ-016 FSM states SHALL be IDLE, WR_CHAR, WR_SPACE.
REQ-017 IDLE, simultaneous strobes: accept exactly one, priority ascii > left > right > down; each unaccepted strobe pulses o_drop (single pulse per cycle).
REQ-018 IDLE, i_ascii_en with i_ascii != 8'h08: latch char, drive o_wr_dat=char, o_wr_addr=current cursor, o_wr_req=1 next cycle, go WR_CHAR.
REQ-019 WR_CHAR: o_wr_req, o_wr_addr, o_wr_dat stable until cycle with i_wr_ack=1; that cycle cursor advances right (REQ-023) and FSM returns IDLE; o_wr_req low next cycle.
REQ-020 IDLE, backspace: if cursor at (0,0) no write, no move, no drop; else cursor moves left (REQ-024) next cycle, then WR_SPACE writes 8'h20 at new cursor; on ack return IDLE, cursor unchanged.
REQ-021 IDLE, arrow strobe: cursor updated on next edge, no write, stay IDLE.
REQ-022 Any strobe while o_busy=1 SHALL be discarded with o_drop pulse; i_wr_ack outside WR_* ignored.
REQ-023 Right: col+1; at col=COLS-1 behaviour per REQ-030/031.
REQ-024 Left: col-1; at col=0 and row>0 -> (row-1, COLS-1); at (0,0) stays.
REQ-025 Down: row+1 modulo ROWS, col unchanged.
REQ-026 o_wr_addr SHALL be computed from registered cursor, no overflow beyond ROWS*COLS-1.
REQ-027 Write latency: o_wr_req asserts exactly 1 cycle after accepted ascii strobe (2 for backspace).

Reset
REQ-028 On i_arst_n low (async) or i_sclr high (sync): state IDLE, cursor (0,0), o_wr_req=0, o_wr_addr=0, o_wr_dat=8'h00, o_busy=0, o_drop=0.
REQ-029 Reset mid-write SHALL abandon the request immediately; late i_wr_ack after reset ignored.

Configuration
REQ-030 With CURSOR_WRAP_EN defined: right at col=COLS-1 -> (row+1 mod ROWS, 0), including after WR_CHAR ack.
REQ-031 Without CURSOR_WRAP_EN: right at col=COLS-1 saturates, cursor unchanged; subsequent chars overwrite last column.

Structure
REQ-032 Shared header edit_defs.vh SHALL hold state encodings, ASCII_BS=8'h08, ASCII_SPACE=8'h20.
REQ-033 Cursor arithmetic SHALL be a sub-module cursor_pos (inputs move-left/right/down, outputs row/col).

Verification
REQ-034 Reset, i_ascii=8'h41 strobe, ack after 3 cycles -> o_wr_req high cycles 1..4, addr 0, dat 8'h41, cursor (0,1).
REQ-035 Cursor (0,3), backspace, ack 1 cycle later -> cursor (0,2), write addr 2 dat 8'h20, o_busy low after ack.
REQ-036 Cursor (0,15), right strobe -> wrap build (1,0); non-wrap build (0,15).
REQ-037 Same-cycle ascii + left + down in IDLE -> char write only, one o_drop pulse, cursor unchanged until ack.
REQ-038 Right strobe during WR_CHAR -> o_drop pulse, cursor only advanced by ack.
REQ-039 i_arst_n low while o_wr_req=1 -> all outputs reset immediately; ack next cycle -> no cursor change.
